wide_pattern_gen: RTL and testbench
===================================

// Module: wide_pattern_gen
// PURPOSE
//  Parametrised wide-vector pattern generator for VCD/waveform regression.
//  A WIDTH-bit register is loaded, then stepped for a programmed burst of cycles by one of
//  four modes: hold, rotate-left, rotate-right, add-step.
//  Exercises VCD encoding of arbitrary-width vectors, carry/wrap and handshakes in one block.
//  Sits under test tops as the stimulus source that $dumpvars captures.
// PARAMETERS
//  WIDTH     128  width of pattern register (>=2)
//  ROT_AMT   1    rotate distance per step, 1..WIDTH-1
//  CNT_W     16   width of burst length / cycle counter
//  RESET_VAL 0    value loaded into pattern on reset (WIDTH bits)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  load_valid in   1      request to load load_data into pattern
//  load_ready out  1      1 iff FSM in IDLE; load accepted when valid&&ready
//  load_data  in   WIDTH  new pattern value
//  start      in   1      begin burst (sampled in IDLE only)
//  mode       in   2      00 hold, 01 rotl, 10 rotr, 11 add; latched at start
//  step       in   WIDTH  addend for add mode; latched at start
//  burst_len  in   CNT_W  number of update cycles; latched at start
//  abort      in   1      terminate RUN early
//  busy       out  1      1 in RUN
//  done       out  1      one-cycle pulse in DONE
//  value      out  WIDTH  current pattern
//  carry      out  1      status of most recent update
//  cycle_cnt  out  CNT_W  updates performed in current/last burst
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, value=RESET_VAL, carry=0, cycle_cnt=0,
//    busy=0, done=0, load_ready=1. Reset mid-burst discards the burst entirely.
//  FSM states: IDLE, RUN, DONE. busy/done/load_ready are decoded from state (registered).
//  IDLE:
//   - load_valid && load_ready: value<=load_data next edge; carry, cycle_cnt unchanged.
//   - Priority: load beats start in the same cycle; start is ignored that cycle.
//   - start (no load): latch mode/step/burst_len; carry<=0, cycle_cnt<=0.
//   - On start: burst_len==0 -> DONE (no update); else -> RUN.
//  RUN: at every rising edge, value updates once, cycle_cnt+=1.
//   - rotl: value<=rotate-left by ROT_AMT; carry<=old value[WIDTH-1].
//   - rotr: value<=rotate-right by ROT_AMT; carry<=old value[0].
//   - add: {carry,value}<=value+step, i.e. WIDTH+1-bit sum; value wraps mod 2^WIDTH.
//   - hold: value unchanged; carry<=0.
//   - Edge performing update number burst_len -> DONE.
//   - abort=1 at an edge: no update; -> IDLE. done never asserted;
//     value and cycle_cnt keep last values.
//   - abort takes priority over the final update.
//   - load_valid and start are ignored while in RUN.
//  DONE: done=1 for exactly one cycle; -> IDLE unconditionally.
//   - load/start/abort ignored in DONE.
//  Latency: start at edge T -> busy from T; first update at edge T+1;
//   last update at edge T+burst_len; done high for cycle T+burst_len..T+burst_len+1.
//  cycle_cnt saturates naturally; burst_len<=2^CNT_W-1 so it cannot wrap.
//  No combinational path from inputs to outputs.
// TESTING
//  1 WIDTH=32: load 0xDEADBEEF, rotl, burst_len=4
//     -> value 0xEADBEEFD, cycle_cnt=4, done pulses 1 cycle, carry=1.
//  2 WIDTH=64: load 0xCAFEBABE_DEADBEEF, add step 0x1111111111111111, burst 2
//     -> 0xED20DCE1_00CFE111, carry=0.
//  3 WIDTH=64: load all-ones, add step 1, burst 1 -> value 0, carry=1.
//  4 WIDTH=128: load 0x0123456789ABCDEF_FEDCBA9876543210, rotr, burst 1
//     -> 0x0091A2B3C4D5E6F7_FF6E5D4C3B2A1908, carry=0.
//  5 Burst 10 add, abort on 4th RUN edge
//     -> cycle_cnt=3, busy drops, no done, load_ready=1.
//  6 burst_len=0 -> done next cycle, value unchanged.
//  7 Boundary: load+start same cycle -> only load taken.
//  8 rst_n low mid-RUN -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/wide_pattern_gen.sv
// wide_pattern_gen
//   Wide-vector pattern generator. A WIDTH-bit pattern register is loaded
//   through a valid/ready handshake, then stepped for a programmed burst by
//   one of four modes (hold, rotate-left, rotate-right, add-step). Used as a
//   stimulus source under waveform-regression test tops.
//
// Parameters
//   WIDTH      pattern width (>= 2)
//   ROT_AMT    rotate distance per step (1..WIDTH-1)
//   CNT_W      width of burst length and cycle counter
//   RESET_VAL  pattern value after reset
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   load request; accepted when load_ready is high
//   load_ready  out  high only while idle
//   load_data   in   new pattern value
//   start       in   begin a burst (sampled only while idle, loses to load)
//   mode        in   00 hold, 01 rotl, 10 rotr, 11 add (latched at start)
//   step        in   addend for add mode (latched at start)
//   burst_len   in   number of update cycles (latched at start)
//   abort       in   terminate a running burst without updating
//   busy        out  high while the burst is running
//   done        out  one-cycle pulse after the final update
//   value       out  current pattern
//   carry       out  status bit of the most recent update
//   cycle_cnt   out  updates performed in the current/last burst
module wide_pattern_gen #(
  parameter int unsigned       WIDTH     = 128,
  parameter int unsigned       ROT_AMT   = 1,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    M_HOLD = 2'b00,
    M_ROTL = 2'b01,
    M_ROTR = 2'b10,
    M_ADD  = 2'b11
  } mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q,  mode_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] step_q,  step_d;
  logic [CNT_W-1:0] len_q,   len_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] rotl_val;
  logic [WIDTH-1:0] rotr_val;
  logic [WIDTH:0]   sum_val;
  logic [CNT_W-1:0] cnt_inc;

  assign rotl_val = (value_q << ROT_AMT) | (value_q >> (WIDTH - ROT_AMT));
  assign rotr_val = (value_q >> ROT_AMT) | (value_q << (WIDTH - ROT_AMT));
  assign sum_val  = {1'b0, value_q} + {1'b0, step_q};
  assign cnt_inc  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    value_d = value_q;
    step_d  = step_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;

    unique case (state_q)
      ST_IDLE: begin
        // load wins over start when both arrive in the same cycle
        if (load_valid) begin
          value_d = load_data;
        end else if (start) begin
          mode_d  = mode_t'(mode);
          step_d  = step;
          len_d   = burst_len;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = (burst_len == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // abort suppresses the update, including the one that would finish
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          unique case (mode_q)
            M_HOLD: begin
              carry_d = 1'b0;
            end
            M_ROTL: begin
              value_d = rotl_val;
              carry_d = value_q[WIDTH-1];
            end
            M_ROTR: begin
              value_d = rotr_val;
              carry_d = value_q[0];
            end
            M_ADD: begin
              value_d = sum_val[WIDTH-1:0];
              carry_d = sum_val[WIDTH];
            end
            default: begin
              carry_d = 1'b0;
            end
          endcase
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= M_HOLD;
      value_q <= RESET_VAL;
      step_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      value_q <= value_d;
      step_q  <= step_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  assign load_ready = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign value      = value_q;
  assign carry      = carry_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_wide_pattern_gen.sv
module tb_wide_pattern_gen;

  localparam int W   = 128;
  localparam int CW  = 16;
  localparam int ROT = 1;

  typedef struct {
    logic [W-1:0]  ld;
    logic [1:0]    md;
    logic [W-1:0]  st;
    logic [CW-1:0] len;
    int            abort_at;
    logic [W-1:0]  ev;
    logic          ec;
    logic [CW-1:0] ecnt;
    int            edone;
    int            ebusy;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_data;
  logic          start;
  logic [1:0]    mode;
  logic [W-1:0]  step;
  logic [CW-1:0] burst_len;
  logic          abort;
  logic          busy;
  logic          done;
  logic [W-1:0]  value;
  logic          carry;
  logic [CW-1:0] cycle_cnt;

  int tests = 0;
  int fails = 0;

  vec_t vecs[10];

  wide_pattern_gen #(
    .WIDTH     (W),
    .ROT_AMT   (ROT),
    .CNT_W     (CW),
    .RESET_VAL ('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .start      (start),
    .mode       (mode),
    .step       (step),
    .burst_len  (burst_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .value      (value),
    .carry      (carry),
    .cycle_cnt  (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [W-1:0] rand_w();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: apply the burst rules directly on a doubled vector / wide sum.
  task automatic model(input logic [W-1:0] ld, input logic [1:0] md, input logic [W-1:0] st,
                       input int len, input int abort_at,
                       output logic [W-1:0] v, output logic c, output logic [CW-1:0] cnt,
                       output int done_n, output int busy_n);
    logic [2*W-1:0] dbl;
    logic [W:0]     s;
    bit             aborted;
    int             nupd;
    aborted = (abort_at > 0) && (abort_at <= len);
    nupd    = aborted ? abort_at - 1 : len;
    v = ld;
    c = 1'b0;
    for (int i = 0; i < nupd; i++) begin
      dbl = {v, v};
      case (md)
        2'd0: c = 1'b0;
        2'd1: begin c = v[W-1]; v = dbl[2*W-1-ROT -: W]; end
        2'd2: begin c = v[0];   v = dbl[ROT +: W]; end
        default: begin s = {1'b0, v} + {1'b0, st}; c = s[W]; v = s[W-1:0]; end
      endcase
    end
    cnt    = CW'(nupd);
    done_n = aborted ? 0 : 1;
    busy_n = aborted ? abort_at : len;
  endtask

  task automatic run_burst(input logic [W-1:0] ld, input logic [1:0] md, input logic [W-1:0] st,
                           input logic [CW-1:0] len, input int abort_at,
                           output logic [W-1:0] v, output logic c, output logic [CW-1:0] cnt,
                           output int done_n, output int busy_n);
    int k;
    int guard;
    load_valid = 1'b1;
    load_data  = ld;
    tick();
    load_valid = 1'b0;
    chk("load value", value, ld);
    start     = 1'b1;
    mode      = md;
    step      = st;
    burst_len = len;
    tick();
    start     = 1'b0;
    mode      = 2'($urandom_range(0, 3));
    step      = rand_w();
    burst_len = CW'($urandom());
    k = 0; guard = 0; done_n = 0; busy_n = 0;
    while (1) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (load_ready) break;
      if (guard > int'(len) + 8) begin
        tests++; fails++;
        $display("FAIL burst timeout: got no return to idle expected idle within %0d cycles", guard);
        break;
      end
      if (busy) begin
        k++;
        abort = (k == abort_at);
      end
      // noise that must be ignored outside IDLE
      load_valid = 1'($urandom_range(0, 1));
      load_data  = rand_w();
      start      = 1'($urandom_range(0, 1));
      tick();
      guard++;
      abort = 1'b0; load_valid = 1'b0; start = 1'b0;
    end
    v = value; c = carry; cnt = cycle_cnt;
  endtask

  initial begin
    logic [W-1:0]  v, ev, x;
    logic          c, ec;
    logic [CW-1:0] cnt, ecnt;
    int            dn, bn, edn, ebn;
    int            len, ab;
    logic [1:0]    md;
    logic [W-1:0]  ld, st;

    //           ld                                        md    step                  len ab  exp value                                   c     cnt done busy
    vecs[0] = '{{4{32'hDEADBEEF}},                        2'd1, '0,                   4,  0, {4{32'hEADBEEFD}},                          1'b1, 4, 1, 4};
    vecs[1] = '{128'hCAFEBABE_DEADBEEF,                   2'd3, 128'h1111111111111111, 2,  0, 128'hED20DCE1_00CFE111,                     1'b0, 2, 1, 2};
    vecs[2] = '{128'h0123456789ABCDEF_FEDCBA9876543210,   2'd2, '0,                   1,  0, 128'h0091A2B3C4D5E6F7_FF6E5D4C3B2A1908,     1'b0, 1, 1, 1};
    vecs[3] = '{128'h0,                                   2'd3, 128'h5,               10, 4, 128'hF,                                     1'b0, 3, 0, 4};
    vecs[4] = '{128'h1234,                                2'd3, 128'h7,               0,  0, 128'h1234,                                  1'b0, 0, 1, 0};
    vecs[5] = '{128'hAA,                                  2'd0, '0,                   3,  0, 128'hAA,                                    1'b0, 3, 1, 3};
    vecs[6] = '{128'h1,                                   2'd1, '0,                   5,  1, 128'h1,                                     1'b0, 0, 0, 1};
    vecs[7] = '{128'h0,                                   2'd3, 128'h1,               3,  3, 128'h2,                                     1'b0, 2, 0, 3};
    vecs[8] = '{128'h1,                                   2'd2, '0,                   1,  0, {1'b1, 127'h0},                             1'b1, 1, 1, 1};
    vecs[9] = '{{W{1'b1}},                                2'd3, 128'h1,               1,  0, 128'h0,                                     1'b1, 1, 1, 1};

    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
    mode = 2'd0; step = '0; burst_len = '0; abort = 1'b0;
    #3;
    chk("reset value",      value,     '0);
    chk("reset carry",      W'(carry), '0);
    chk("reset cycle_cnt",  W'(cycle_cnt), '0);
    chk("reset busy",       W'(busy),  '0);
    chk("reset done",       W'(done),  '0);
    chk("reset load_ready", W'(load_ready), W'(1));
    #9 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_burst(vecs[i].ld, vecs[i].md, vecs[i].st, vecs[i].len, vecs[i].abort_at, v, c, cnt, dn, bn);
      chk($sformatf("vec%0d value", i), v, vecs[i].ev);
      chk($sformatf("vec%0d carry", i), W'(c), W'(vecs[i].ec));
      chk($sformatf("vec%0d cycle_cnt", i), W'(cnt), W'(vecs[i].ecnt));
      chk($sformatf("vec%0d done cycles", i), W'(dn), W'(vecs[i].edone));
      chk($sformatf("vec%0d busy cycles", i), W'(bn), W'(vecs[i].ebusy));
    end

    // load and start together: only the load happens; carry/cnt keep vec9 results
    x = rand_w();
    load_valid = 1'b1; load_data = x; start = 1'b1; mode = 2'd3; step = 128'h1; burst_len = 16'd5;
    tick();
    load_valid = 1'b0; start = 1'b0;
    chk("ld+start value",      value,          x);
    chk("ld+start busy",       W'(busy),       '0);
    chk("ld+start load_ready", W'(load_ready), W'(1));
    chk("ld+start carry",      W'(carry),      W'(1));
    chk("ld+start cycle_cnt",  W'(cycle_cnt),  W'(1));
    tick();
    chk("ld+start still idle", W'(busy),       '0);

    for (int r = 0; r < 40; r++) begin
      md  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 12);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
      ld  = rand_w();
      st  = ($urandom_range(0, 1) == 0) ? rand_w() : ~W'($urandom_range(0, 3));
      model(ld, md, st, len, ab, ev, ec, ecnt, edn, ebn);
      run_burst(ld, md, st, CW'(len), ab, v, c, cnt, dn, bn);
      chk($sformatf("rnd%0d value", r), v, ev);
      chk($sformatf("rnd%0d carry", r), W'(c), W'(ec));
      chk($sformatf("rnd%0d cycle_cnt", r), W'(cnt), W'(ecnt));
      chk($sformatf("rnd%0d done cycles", r), W'(dn), W'(edn));
      chk($sformatf("rnd%0d busy cycles", r), W'(bn), W'(ebn));
    end

    // asynchronous reset in the middle of a burst
    load_valid = 1'b1; load_data = {W{1'b1}};
    tick();
    load_valid = 1'b0;
    start = 1'b1; mode = 2'd3; step = {W{1'b1}}; burst_len = 16'd100;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre-reset busy",      W'(busy),      W'(1));
    chk("pre-reset carry",     W'(carry),     W'(1));
    chk("pre-reset cycle_cnt", W'(cycle_cnt), W'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst value",      value,          '0);
    chk("async rst carry",      W'(carry),      '0);
    chk("async rst cycle_cnt",  W'(cycle_cnt),  '0);
    chk("async rst busy",       W'(busy),       '0);
    chk("async rst done",       W'(done),       '0);
    chk("async rst load_ready", W'(load_ready), W'(1));
    #10 rst_n = 1'b1;
    tick(); tick();
    chk("post-reset busy",      W'(busy),       '0);
    chk("post-reset cycle_cnt", W'(cycle_cnt),  '0);
    chk("post-reset value",     value,          '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
